// File: rtl/c_reg_fd_if.sv
// c_reg_fd_if: data and control bundle for the c_reg_fd register.
// There is no valid/ready handshake on this bundle. The slave samples D and the
// sync controls on every rising clock edge. The async controls act as levels.
// Q is a registered output.
interface c_reg_fd_if #(
  parameter int C_WIDTH = 16
);
  logic [C_WIDTH-1:0] D;
  logic               CE;
  logic               ASET;
  logic               AINIT;
  logic               SCLR;
  logic               SSET;
  logic               SINIT;
  logic [C_WIDTH-1:0] Q;

  modport master (output D, CE, ASET, AINIT, SCLR, SSET, SINIT, input Q);
  modport slave  (input D, CE, ASET, AINIT, SCLR, SSET, SINIT, output Q);
endinterface

// File: rtl/c_reg_fd.sv
// c_reg_fd: configurable D register with async clear/set/init and sync
// clear/set/init, plus an optional clock enable.
// The init values are given as MSB-first strings of '0'/'1'. Character i from
// the right maps to bit i-1. Any other character, including NUL, gives 0.
// Optional macro C_REG_FD_PARAM_CHECK_EN checks the string and sync parameters
// at elaboration and stops the build on a bad value.
module c_reg_fd #(
  parameter int                   C_WIDTH         = 16,
  parameter logic [8*C_WIDTH-1:0] C_AINIT_VAL     = "",
  parameter logic [8*C_WIDTH-1:0] C_SINIT_VAL     = "",
  parameter int                   C_ENABLE_RLOCS  = 1,
  parameter int                   C_HAS_CE        = 0,
  parameter int                   C_HAS_ACLR      = 1,
  parameter int                   C_HAS_ASET      = 0,
  parameter int                   C_HAS_AINIT     = 0,
  parameter int                   C_HAS_SCLR      = 0,
  parameter int                   C_HAS_SSET      = 0,
  parameter int                   C_HAS_SINIT     = 0,
  parameter int                   C_SYNC_ENABLE   = 0,
  parameter int                   C_SYNC_PRIORITY = 1
) (
  input logic         CLK,
  input logic         ACLR_N,
  c_reg_fd_if.slave   bus
);

  // Converts a packed init string to a bit vector. The string is already
  // zero-extended on the left to C_WIDTH characters, so a short string gives
  // zero MSBs.
  function automatic logic [C_WIDTH-1:0] str_to_bits(input logic [8*C_WIDTH-1:0] s);
    logic [C_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < C_WIDTH; i++) begin
      r[i] = (s[8*i +: 8] == 8'h31);
    end
    return r;
  endfunction

  localparam logic [C_WIDTH-1:0] AINIT_V = str_to_bits(C_AINIT_VAL);
  localparam logic [C_WIDTH-1:0] SINIT_V = str_to_bits(C_SINIT_VAL);
  localparam logic [C_WIDTH-1:0] ONES_V  = '1;

`ifdef C_REG_FD_PARAM_CHECK_EN
  // Accepts only '0', '1' or NUL in every character position.
  function automatic bit str_is_valid(input logic [8*C_WIDTH-1:0] s);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < C_WIDTH; i++) begin
      if (s[8*i +: 8] != 8'h00 && s[8*i +: 8] != 8'h30 && s[8*i +: 8] != 8'h31) ok = 1'b0;
    end
    return ok;
  endfunction

  if (!str_is_valid(C_AINIT_VAL)) begin : g_bad_ainit
    $fatal(1, "c_reg_fd: C_AINIT_VAL \"%s\" contains a character other than 0/1", C_AINIT_VAL);
  end
  if (!str_is_valid(C_SINIT_VAL)) begin : g_bad_sinit
    $fatal(1, "c_reg_fd: C_SINIT_VAL \"%s\" contains a character other than 0/1", C_SINIT_VAL);
  end
  if (C_SYNC_ENABLE < 0 || C_SYNC_ENABLE > 1) begin : g_bad_sync_en
    $fatal(1, "c_reg_fd: C_SYNC_ENABLE must be 0 or 1");
  end
  if (C_SYNC_PRIORITY < 0 || C_SYNC_PRIORITY > 1) begin : g_bad_sync_pri
    $fatal(1, "c_reg_fd: C_SYNC_PRIORITY must be 0 or 1");
  end
`else
  // Without the check, invalid characters simply convert to 0.
`endif

  // The placement hint carries no logic.
  if (C_ENABLE_RLOCS != 0) begin : g_rlocs_hint
  end

  // A disabled control is tied to its inactive level.
  logic aclr_n_w;
  logic aset_w;
  logic ainit_w;
  logic ce_w;
  logic sclr_w;
  logic sset_w;
  logic sinit_w;

  assign aclr_n_w = (C_HAS_ACLR  != 0) ? ACLR_N    : 1'b1;
  assign aset_w   = (C_HAS_ASET  != 0) ? bus.ASET  : 1'b0;
  assign ainit_w  = (C_HAS_AINIT != 0) ? bus.AINIT : 1'b0;
  assign ce_w     = (C_HAS_CE    != 0) ? bus.CE    : 1'b1;
  assign sclr_w   = (C_HAS_SCLR  != 0) ? bus.SCLR  : 1'b0;
  assign sset_w   = (C_HAS_SSET  != 0) ? bus.SSET  : 1'b0;
  assign sinit_w  = (C_HAS_SINIT != 0) ? bus.SINIT : 1'b0;

  // The register powers up at the async-init value.
  logic [C_WIDTH-1:0] q_q = AINIT_V;
  logic [C_WIDTH-1:0] q_d;

  // Next value on a clock edge. SCLR/SSET beat SINIT, and SINIT beats a CE
  // load. With C_SYNC_ENABLE set, CE=0 also masks the sync controls.
  always_comb begin
    q_d = q_q;
    if (C_SYNC_ENABLE == 0 || ce_w) begin
      if (sclr_w && sset_w) begin
        q_d = (C_SYNC_PRIORITY != 0) ? '0 : ONES_V;
      end else if (sclr_w) begin
        q_d = '0;
      end else if (sset_w) begin
        q_d = ONES_V;
      end else if (sinit_w) begin
        q_d = SINIT_V;
      end else if (ce_w) begin
        q_d = bus.D;
      end
    end
  end

  // State register. Clear beats set, and set beats init. While any async
  // control is active, clock edges only re-apply it. ACLR_N release must meet
  // recovery against CLK, so the first load comes on a later edge.
  always_ff @(posedge CLK or negedge aclr_n_w or posedge aset_w or posedge ainit_w) begin
    if (!aclr_n_w) begin
      q_q <= '0;
    end else if (aset_w) begin
      q_q <= ONES_V;
    end else if (ainit_w) begin
      q_q <= AINIT_V;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.Q = q_q;

endmodule

// File: tb/tb_c_reg_fd.sv
// tb_c_reg_fd: scoreboard bench for c_reg_fd with three configurations
// sharing one clock and one ACLR_N.
// Instance u0 has all controls enabled, sync overrides CE, and SCLR wins.
// Instance u1 is the same, but sync acts only with CE=1, and SSET wins.
// Instance u2 uses the default parameters: 16 bits, ACLR only, no CE.
module tb_c_reg_fd;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic aclr_n = 1'b1;
  always #5 clk = ~clk;

  c_reg_fd_if #(.C_WIDTH(4))  i0 ();
  c_reg_fd_if #(.C_WIDTH(4))  i1 ();
  c_reg_fd_if #(.C_WIDTH(16)) i2 ();

  c_reg_fd #(
    .C_WIDTH(4), .C_AINIT_VAL("0110"), .C_SINIT_VAL("1001"),
    .C_HAS_CE(1), .C_HAS_ACLR(1), .C_HAS_ASET(1), .C_HAS_AINIT(1),
    .C_HAS_SCLR(1), .C_HAS_SSET(1), .C_HAS_SINIT(1),
    .C_SYNC_ENABLE(0), .C_SYNC_PRIORITY(1)
  ) u0 (.CLK(clk), .ACLR_N(aclr_n), .bus(i0));

  c_reg_fd #(
    .C_WIDTH(4), .C_AINIT_VAL("0110"), .C_SINIT_VAL("1001"),
    .C_HAS_CE(1), .C_HAS_ACLR(1), .C_HAS_ASET(1), .C_HAS_AINIT(1),
    .C_HAS_SCLR(1), .C_HAS_SSET(1), .C_HAS_SINIT(1),
    .C_SYNC_ENABLE(1), .C_SYNC_PRIORITY(0)
  ) u1 (.CLK(clk), .ACLR_N(aclr_n), .bus(i1));

  c_reg_fd u2 (.CLK(clk), .ACLR_N(aclr_n), .bus(i2));

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ctrl(input logic ce, input logic sclr, input logic sset, input logic sinit);
    i0.CE = ce; i0.SCLR = sclr; i0.SSET = sset; i0.SINIT = sinit;
    i1.CE = ce; i1.SCLR = sclr; i1.SSET = sset; i1.SINIT = sinit;
    i2.CE = ce; i2.SCLR = sclr; i2.SSET = sset; i2.SINIT = sinit;
  endtask

  task automatic set_async(input logic aset, input logic ainit);
    i0.ASET = aset; i0.AINIT = ainit;
    i1.ASET = aset; i1.AINIT = ainit;
    i2.ASET = aset; i2.AINIT = ainit;
  endtask

  // Drives one clock edge of sync stimulus, queues the expected values, and
  // compares them just after the edge.
  task automatic drive_sync(input logic ce, input logic [3:0] d, input logic sclr,
                            input logic sset, input logic sinit,
                            input logic [3:0] e0, input logic [3:0] e1);
    logic [15:0] d2;
    d2 = 16'($urandom_range(0, 65535));
    @(negedge clk);
    set_ctrl(ce, sclr, sset, sinit);
    i0.D = d; i1.D = d; i2.D = d2;
    exp_q0.push_back({12'h000, e0});
    exp_q1.push_back({12'h000, e1});
    exp_q2.push_back(d2);
    @(posedge clk);
    #1;
    check("u0_sync", {12'h000, i0.Q}, exp_q0.pop_front());
    check("u1_sync", {12'h000, i1.Q}, exp_q1.pop_front());
    check("u2_load", i2.Q, exp_q2.pop_front());
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] m;
  logic       rce;
  logic [3:0] rd;

  initial begin
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    set_async(1'b0, 1'b0);
    i0.D = '0; i1.D = '0; i2.D = '0;
    #1;
    // Power-up value is the async-init string.
    check("pwr_u0", {12'h000, i0.Q}, 16'h0006);
    check("pwr_u1", {12'h000, i1.Q}, 16'h0006);
    check("pwr_u2", i2.Q, 16'h0000);

    //         ce    d     sclr  sset  sinit  u0     u1
    drive_sync(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA);
    drive_sync(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA);
    drive_sync(1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 4'hA);
    drive_sync(1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF);
    drive_sync(1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'h9, 4'hF);
    drive_sync(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'h9, 4'h9);
    drive_sync(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    drive_sync(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
    drive_sync(1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
    drive_sync(1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'h9, 4'h9);
    drive_sync(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 4'hC);

    // Async phase: u0/u1 hold on clock edges (CE=0). u2 reloads FFFF on every edge.
    @(negedge clk);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    i2.D = 16'hFFFF;
    @(negedge clk);
    #1 aclr_n = 1'b0;
    #1;
    check("aclr_u0", {12'h000, i0.Q}, 16'h0000);
    check("aclr_u1", {12'h000, i1.Q}, 16'h0000);
    check("aclr_u2", i2.Q, 16'h0000);
    @(negedge clk);
    #1 set_async(1'b1, 1'b0);
    #1;
    check("aclr_aset_u0", {12'h000, i0.Q}, 16'h0000);
    check("aclr_edge_u2", i2.Q, 16'h0000);
    @(negedge clk);
    #1 set_async(1'b0, 1'b0);
    #1;
    check("aclr_only_u1", {12'h000, i1.Q}, 16'h0000);
    #1 aclr_n = 1'b1;
    #1;
    check("aclr_rel_u0", {12'h000, i0.Q}, 16'h0000);
    check("aclr_rel_u2", i2.Q, 16'h0000);

    @(negedge clk);
    #1;
    i0.CE = 1'b1; i0.D = 4'h3; i1.CE = 1'b1; i1.D = 4'h3;
    set_async(1'b1, 1'b0);
    #1;
    check("aset_u0", {12'h000, i0.Q}, 16'h000F);
    check("aset_u1", {12'h000, i1.Q}, 16'h000F);
    check("aset_ign_u2", i2.Q, 16'hFFFF);
    @(negedge clk);
    #1;
    check("aset_edge_u0", {12'h000, i0.Q}, 16'h000F);
    set_async(1'b0, 1'b0);
    i0.CE = 1'b0; i1.CE = 1'b0;
    #1;
    check("aset_rel_u1", {12'h000, i1.Q}, 16'h000F);

    @(negedge clk);
    #1;
    i0.CE = 1'b1; i1.CE = 1'b1;
    set_async(1'b0, 1'b1);
    #1;
    check("ainit_u0", {12'h000, i0.Q}, 16'h0006);
    check("ainit_u1", {12'h000, i1.Q}, 16'h0006);
    check("ainit_ign_u2", i2.Q, 16'hFFFF);
    @(negedge clk);
    #1;
    check("ainit_edge_u1", {12'h000, i1.Q}, 16'h0006);
    set_async(1'b0, 1'b0);
    i0.CE = 1'b0; i1.CE = 1'b0;
    #1;
    check("ainit_rel_u0", {12'h000, i0.Q}, 16'h0006);

    // Random CE/D traffic with no sync controls.
    m = 4'h6;
    for (int k = 0; k < 24; k++) begin
      rce = 1'($urandom_range(0, 1));
      rd  = 4'($urandom_range(0, 15));
      if (rce) m = rd;
      drive_sync(rce, rd, 1'b0, 1'b0, 1'b0, m, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
